// File: rtl/flit_link_sink_if.sv
// Split-flit link bundle: two half-flit inputs plus clear going in,
// reassembled flit and link statistics coming out.
interface flit_link_sink_if #(
  parameter int N  = 9,
  parameter int CW = 16,
  parameter int TW = 24,
  parameter int LW = 8
);
  logic             flit_valid;
  logic [N-1:0]     flit_lo;
  logic [N-1:0]     flit_hi;
  logic             clr;
  logic [2*N-1:0]   flit_out;
  logic             flit_out_valid;
  logic             pkt_done;
  logic [LW-1:0]    last_len;
  logic [CW-1:0]    pkt_count;
  logic [CW-1:0]    flit_count;
  logic [CW-1:0]    idle_count;
  logic [TW-1:0]    toggle_count;
  logic             len_err;
  logic             gap_err;

  modport master (
    output flit_valid, flit_lo, flit_hi, clr,
    input  flit_out, flit_out_valid, pkt_done, last_len, pkt_count,
           flit_count, idle_count, toggle_count, len_err, gap_err
  );

  modport slave (
    input  flit_valid, flit_lo, flit_hi, clr,
    output flit_out, flit_out_valid, pkt_done, last_len, pkt_count,
           flit_count, idle_count, toggle_count, len_err, gap_err
  );
endinterface

// File: rtl/flit_link_sink.sv
// Receive endpoint of the split-flit link: reassembles flits, delimits packets
// by valid runs, checks length/gap and accumulates utilization/toggle stats.
module flit_link_sink #(
  parameter int N       = 9,
  parameter int PAYLOAD = 20,
  parameter int MIN_GAP = 7,
  parameter int CW      = 16,
  parameter int TW      = 24,
  parameter int LW      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  flit_link_sink_if.slave  lnk
);
  localparam int FW = 2 * N;
  localparam int PW = $clog2(FW + 1);
  localparam int GW = $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_GAP} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_len;
  logic [GW-1:0]   r_gap;
  logic            r_pkt_done;
  logic [LW-1:0]   r_last_len;
  logic [CW-1:0]   r_pkt_cnt, r_flit_cnt, r_idle_cnt;
  logic            r_len_err, r_gap_err;
  logic [FW-1:0]   r_fout;
  logic            r_fov;
  logic [FW-1:0]   r_prev;
  logic [PW-1:0]   r_pop;
  logic            r_pop_vld;
  logic [TW-1:0]   r_tog;

  logic [FW-1:0]   w_flit, w_diff;
  logic [PW-1:0]   w_pop;
  logic [TW:0]     w_tog_sum;

  assign w_flit    = {lnk.flit_hi, lnk.flit_lo};
  assign w_diff    = w_flit ^ r_prev;
  assign w_tog_sum = {1'b0, r_tog} + {{(TW + 1 - PW){1'b0}}, r_pop};

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < FW; i++) w_pop = w_pop + PW'(w_diff[i]);
  end

  // Data path ignores clr so the last observed flit stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fout <= '0;
      r_fov  <= 1'b0;
    end else begin
      r_fov <= lnk.flit_valid;
      if (lnk.flit_valid) r_fout <= w_flit;
    end
  end

  // Stage 1 latches popcount against the previous valid flit, stage 2 accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev    <= '0;
      r_pop     <= '0;
      r_pop_vld <= 1'b0;
      r_tog     <= '0;
    end else if (lnk.clr) begin
      r_prev    <= '0;
      r_pop     <= '0;
      r_pop_vld <= 1'b0;
      r_tog     <= '0;
    end else begin
      r_pop_vld <= lnk.flit_valid;
      if (lnk.flit_valid) begin
        r_pop  <= w_pop;
        r_prev <= w_flit;
      end
      if (r_pop_vld) r_tog <= w_tog_sum[TW] ? '1 : w_tog_sum[TW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_gap      <= '0;
      r_pkt_done <= 1'b0;
      r_last_len <= '0;
      r_pkt_cnt  <= '0;
      r_flit_cnt <= '0;
      r_idle_cnt <= '0;
      r_len_err  <= 1'b0;
      r_gap_err  <= 1'b0;
    end else if (lnk.clr) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_gap      <= '0;
      r_pkt_done <= 1'b0;
      r_last_len <= '0;
      r_pkt_cnt  <= '0;
      r_flit_cnt <= '0;
      r_idle_cnt <= '0;
      r_len_err  <= 1'b0;
      r_gap_err  <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      if (lnk.flit_valid && r_flit_cnt != '1) r_flit_cnt <= r_flit_cnt + 1'b1;
      if (!lnk.flit_valid && r_state != S_IDLE && r_idle_cnt != '1)
        r_idle_cnt <= r_idle_cnt + 1'b1;
      case (r_state)
        S_IDLE: if (lnk.flit_valid) begin
          r_state <= S_PKT;
          r_len   <= LW'(1);
        end
        S_PKT: if (lnk.flit_valid) begin
          if (r_len != '1) r_len <= r_len + 1'b1;
        end else begin
          r_state    <= S_GAP;
          r_pkt_done <= 1'b1;
          r_last_len <= r_len;
          if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 1'b1;
          if (r_len != LW'(PAYLOAD)) r_len_err <= 1'b1;
          r_gap      <= GW'(1);
        end
        S_GAP: if (lnk.flit_valid) begin
          if (r_gap < GW'(MIN_GAP)) r_gap_err <= 1'b1;
          r_state <= S_PKT;
          r_len   <= LW'(1);
        end else if (r_gap < GW'(MIN_GAP)) begin
          r_gap <= r_gap + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lnk.flit_out       = r_fout;
  assign lnk.flit_out_valid = r_fov;
  assign lnk.pkt_done       = r_pkt_done;
  assign lnk.last_len       = r_last_len;
  assign lnk.pkt_count      = r_pkt_cnt;
  assign lnk.flit_count     = r_flit_cnt;
  assign lnk.idle_count     = r_idle_cnt;
  assign lnk.toggle_count   = r_tog;
  assign lnk.len_err        = r_len_err;
  assign lnk.gap_err        = r_gap_err;
endmodule

// File: doc/flit_link_sink.md
Name: flit_link_sink

Overview:
- Receive-side endpoint for the split-flit link that drives the adder energy-characterization benches. Per cycle, the link presents one 2N-bit flit as two N-bit halves.
- Reassembles each flit and delimits packets as runs of consecutive valid cycles. Checks packet length and inter-packet gap against the configured traffic profile.
- Accumulates flit, packet, idle-cycle and bit-toggle (Hamming) statistics. These give link-utilization and switching-activity figures for energy estimation.

Parameters:
- N, 9, half-flit width; the reassembled flit is 2N bits.
- PAYLOAD, 20, required flits per packet.
- MIN_GAP, 7, minimum idle cycles between packets.
- CW, 16, width of the packet, flit and idle counters.
- TW, 24, width of the toggle accumulator.
- LW, 8, width of the packet-length counter and of last_len.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flit_valid  in  1  flit present this cycle.
- flit_lo  in  N  low half of flit (bits N-1:0).
- flit_hi  in  N  high half of flit (bits 2N-1:N).
- clr  in  1  synchronous clear of statistics and sticky errors.
- flit_out  out  2N  reassembled flit {flit_hi, flit_lo}.
- flit_out_valid  out  1  flit_out qualifier.
- pkt_done  out  1  one-cycle pulse at packet end.
- last_len  out  LW  length of the most recently completed packet.
- pkt_count  out  CW  completed packets.
- flit_count  out  CW  accepted flits.
- idle_count  out  CW  cycles with flit_valid=0, counted only after the first flit.
- toggle_count  out  TW  accumulated Hamming distance between successive valid flits.
- len_err  out  1  sticky: a packet length differed from PAYLOAD.
- gap_err  out  1  sticky: an inter-packet gap was shorter than MIN_GAP.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0, FSM goes to IDLE, and the prev-flit register is cleared to 0.
  - A reset asserted mid-packet discards that packet: no pkt_done and no length check.
- FSM states:
  - IDLE: no flit seen since reset or clr. flit_valid=1 moves to PKT with len=1; no gap check on this first packet.
  - PKT: each valid cycle does len+1, saturating at 2^LW-1. The first cycle with flit_valid=0 moves to GAP; that cycle registers pkt_done=1, last_len=len, pkt_count+1, and sets len_err if len!=PAYLOAD. That cycle also sets gap=1.
  - GAP: each idle cycle does gap+1, saturating at MIN_GAP. When flit_valid=1 arrives, set gap_err if gap<MIN_GAP, then move to PKT with len=1.
- Back-to-back packets cannot occur: a gap of 0 cycles means the two runs are one packet.
- Data path: flit_out and flit_out_valid are registered, 1 cycle latency. flit_out holds its last value when flit_out_valid=0.
- Toggle path (2-stage pipeline):
  - Stage 1 registers popcount(flit ^ prev) on each valid cycle, then prev <= flit.
  - Stage 2 adds that value into toggle_count, which therefore reflects a flit 2 cycles after it was accepted.
  - Idle cycles neither update prev nor add to the count.
- Counters:
  - flit_count increments on each valid cycle.
  - idle_count increments on each invalid cycle in PKT or GAP state.
  - All counters saturate at their all-ones value and never wrap.
- clr:
  - Zeroes pkt_count, flit_count, idle_count, toggle_count, len_err, gap_err, last_len, the toggle pipeline and prev.
  - Returns the FSM to IDLE.
  - clr takes priority: any event in the same cycle is dropped.
  - flit_out is unaffected.
- Sticky errors stay set until rst_n or clr.

Test Plan:
- Reset, then 20 valid flits, then 7 idle cycles -> pkt_done pulses once, on the cycle after the last flit; last_len=20; pkt_count=1; flit_count=20; len_err=0; gap_err=0.
- Two-flit packet 0x3F800 then 0x3FFF0 (N=9) -> flit_out matches each flit 1 cycle later; toggle_count=7 two cycles after the first flit, then 14; after the 12-idle gap, idle_count=12.
- 10 packets of 20 flits separated by 7-idle gaps -> pkt_count=10, flit_count=200, idle_count=70 (final gap counted), no errors.
- Packet of 19 flits, then a packet of 20 after a 6-cycle gap -> len_err=1 after the first packet, gap_err=1 on the first flit of the second packet, last_len=20.
- rst_n pulsed low mid-packet at flit 10 -> all outputs 0 immediately; following clean 20-flit packet -> pkt_count=1, no errors.
- clr asserted in the same cycle as a packet end -> no pkt_done, counters 0; toggle_count saturation at 2^24-1 checked by forcing the accumulator near max.
